// File: rtl/count_checker.sv
// Sequence monitor for a free-running WIDTH-bit up-counter: tracks +1 steps, locks, counts breaks.
// Optional build macro COUNT_CHECK_STICKY_EN: a break while locked latches a terminal FAIL state.
module count_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERRW     = 8
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic [WIDTH-1:0] q,
    output logic             locked,
    output logic             err,
    output logic [WIDTH-1:0] exp,
    output logic [ERRW-1:0]  err_cnt
);
    localparam int RUNW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAIL   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [RUNW-1:0]   run_q, run_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]  q_inc;
    logic [RUNW-1:0]   run_inc;
    logic [ERRW-1:0]   cnt_inc;

    assign q_inc   = q + WIDTH'(1);
    assign run_inc = run_q + RUNW'(1);
    assign cnt_inc = (err_cnt_q == {ERRW{1'b1}}) ? err_cnt_q : err_cnt_q + ERRW'(1);

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        exp_d     = exp_q;
        err_cnt_d = err_cnt_q;
        if (state_q == FAIL) begin
            // Terminal until reset: the alarm stays raised and nothing else moves.
            err_d = 1'b1;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    exp_d   = q_inc;
                    run_d   = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    exp_d = q_inc;
                    if (q == exp_q) begin
                        run_d = run_inc;
                        if (run_inc == RUNW'(LOCK_CNT)) begin
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (q == exp_q) begin
                        exp_d = q_inc;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = cnt_inc;
                        locked_d  = 1'b0;
                        run_d     = '0;
`ifdef COUNT_CHECK_STICKY_EN
                        state_d   = FAIL;
`else
                        exp_d     = q_inc;
                        state_d   = ACQ;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (!res) begin
            state_q   <= IDLE;
            run_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            exp_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            exp_q     <= exp_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign exp     = exp_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: default-parameter DUT plus an ERRW=2 copy sharing the same inputs.
`timescale 1ps/1ps
module tb_count_checker;
    localparam int LOCK = 3;

    logic       ck = 1'b0;
    logic       res = 1'b0;
    logic       en = 1'b0;
    logic [3:0] q = 4'd0;
    logic       locked, err, locked2, err2;
    logic [3:0] exp_o, exp2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: counts correct predictions since the last seed, in plain integers.
    bit seeded;
    bit failed;
    bit err_m;
    int streak;
    int exp_m;
    int errs;

    always #50000 ck = ~ck;

    count_checker #(.WIDTH(4), .LOCK_CNT(LOCK), .ERRW(8)) dut (
        .ck(ck), .res(res), .en(en), .q(q),
        .locked(locked), .err(err), .exp(exp_o), .err_cnt(err_cnt)
    );

    count_checker #(.WIDTH(4), .LOCK_CNT(LOCK), .ERRW(2)) dut2 (
        .ck(ck), .res(res), .en(en), .q(q),
        .locked(locked2), .err(err2), .exp(exp2), .err_cnt(err_cnt2)
    );

    function automatic logic [15:0] model_vec();
        int c8, c2;
        c8 = (errs > 255) ? 255 : errs;
        c2 = (errs > 3) ? 3 : errs;
        return {(streak >= LOCK) && !failed, err_m, 4'(exp_m), 8'(c8), 2'(c2)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {locked, err, exp_o, err_cnt, err_cnt2};
    endfunction

    task automatic drive(input logic r, input logic e, input logic [3:0] v);
        @(negedge ck);
        res = r;
        en  = e;
        q   = v;
        @(posedge ck);
        if (!r) begin
            seeded = 0; failed = 0; err_m = 0; streak = 0; exp_m = 0; errs = 0;
        end else begin
            err_m = 0;
            if (failed) begin
                err_m = 1;
            end else if (e) begin
                if (!seeded) begin
                    seeded = 1;
                    streak = 0;
                    exp_m  = (int'(v) + 1) % 16;
                end else if (int'(v) == exp_m) begin
                    streak = streak + 1;
                    exp_m  = (int'(v) + 1) % 16;
                end else begin
                    if (streak >= LOCK) begin
                        err_m = 1;
                        errs  = errs + 1;
`ifdef COUNT_CHECK_STICKY_EN
                        failed = 1;
`else
                        exp_m  = (int'(v) + 1) % 16;
`endif
                    end else begin
                        exp_m = (int'(v) + 1) % 16;
                    end
                    streak = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 4'd7);
        n_checks++;
        if (dut_vec() !== 16'd0) $display("FAIL reset_outputs got=%h want=0000", dut_vec());
        else n_pass++;
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL reset_model got=%h want=%h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 4'(i % 16));
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL wrap_model i=%0d got=%h want=%h", i, dut_vec(), model_vec());
            else n_pass++;
            if (i == 2 || i == 3) begin
                n_checks++;
                if (locked !== (i == 3)) $display("FAIL lock_timing i=%0d got=%b want=%b", i, locked, i == 3);
                else n_pass++;
            end
            if (i == 15) begin
                n_checks++;
                if (exp_o !== 4'd0 || err !== 1'b0) $display("FAIL wrap_exp got exp=%h err=%b want exp=0 err=0", exp_o, err);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mismatch();
        logic [3:0] tab [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, tab[i]);
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL mismatch_model i=%0d got=%h want=%h", i, dut_vec(), model_vec());
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if ({err, err_cnt, locked, exp_o} !== {1'b1, 8'd1, 1'b0, 4'd10})
                    $display("FAIL mismatch_pulse got err=%b cnt=%0d lk=%b exp=%h want 1 1 0 a", err, err_cnt, locked, exp_o);
                else n_pass++;
            end
            if (i == 5) begin
                n_checks++;
                if (err !== 1'b0) $display("FAIL err_one_cycle got=%b want=0", err);
                else n_pass++;
            end
        end
        n_checks++;
        if (locked !== 1'b1) $display("FAIL relock got=%b want=1", locked);
        else n_pass++;
    endtask

    task automatic test_en_gap();
        bit         e_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] q_tab [7] = '{4'd2, 4'd3, 4'hA, 4'hF, 4'h0, 4'd4, 4'd5};
        drive(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, e_tab[i], q_tab[i]);
            n_checks++;
            if (dut_vec() !== model_vec() || err !== 1'b0 || locked !== (i == 6))
                $display("FAIL en_gap i=%0d got=%h want=%h lk_want=%b", i, dut_vec(), model_vec(), i == 6);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] cnt_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [3:0] cur;
        drive(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'(i));
        cur = 4'd4;
        for (int k = 0; k < 5; k++) begin
            cur = cur + 4'd5;
            drive(1'b1, 1'b1, cur);
            n_checks++;
            if (err2 !== 1'b1 || err_cnt2 !== cnt_tab[k] || err_cnt !== 8'(k + 1))
                $display("FAIL sat k=%0d got err=%b cnt2=%0d cnt8=%0d want 1 %0d %0d", k, err2, err_cnt2, err_cnt, cnt_tab[k], k + 1);
            else n_pass++;
            for (int j = 0; j < 3; j++) begin
                cur = cur + 4'd1;
                drive(1'b1, 1'b1, cur);
            end
            cur = cur + 4'd1;
            n_checks++;
            if (dut_vec() !== model_vec() || locked2 !== 1'b1)
                $display("FAIL sat_relock k=%0d got=%h want=%h lk2=%b", k, dut_vec(), model_vec(), locked2);
            else n_pass++;
        end
    endtask

`ifdef COUNT_CHECK_STICKY_EN
    task automatic test_sticky();
        drive(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'(i));
        drive(1'b1, 1'b1, 4'd9);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 4'(10 + i));
            n_checks++;
            if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || dut_vec() !== model_vec())
                $display("FAIL sticky i=%0d got err=%b cnt=%0d lk=%b want 1 1 0", i, err, err_cnt, locked);
            else n_pass++;
        end
        drive(1'b0, 1'b1, 4'd5);
        n_checks++;
        if (dut_vec() !== 16'd0) $display("FAIL sticky_reset got=%h want=0000", dut_vec());
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [3:0] cur;
        bit         e;
        bit         r;
        logic [3:0] v;
        drive(1'b0, 1'b0, 4'd0);
        cur = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 4) != 0);
            v = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : cur;
            if (e) cur = v + 4'd1;
            drive(r, e, v);
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL random i=%0d got=%h want=%h", i, dut_vec(), model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        seeded = 0; failed = 0; err_m = 0; streak = 0; exp_m = 0; errs = 0;
        test_reset();
        test_count_wrap();
`ifdef COUNT_CHECK_STICKY_EN
        test_sticky();
`else
        test_mismatch();
        test_saturation();
`endif
        test_en_gap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
